// File: rtl/operand_buffer_if.sv
// Operand buffer bus: host/DMA port, control-unit command strobes
// and systolic-array data. master = upstream driver, slave = buffer.
interface operand_buffer_if;
  logic        wr_en;
  logic [4:0]  wr_addr;
  logic [7:0]  wr_data;
  logic [4:0]  rd_addr;
  logic [7:0]  rd_data;
  logic [4:0]  base_address;
  logic        load_weight;
  logic        load_input;
  logic        store_res;
  logic [31:0] result_in;
  logic [31:0] weights_out;
  logic        weight_valid;
  logic [7:0]  a_lane0;
  logic [7:0]  a_lane1;
  logic        input_valid;
  logic        busy;
  logic        done;

  modport master (
    output wr_en, wr_addr, wr_data, rd_addr,
    output base_address, load_weight,
    output load_input, store_res, result_in,
    input  rd_data, weights_out, weight_valid,
    input  a_lane0, a_lane1, input_valid,
    input  busy, done
  );

  modport slave (
    input  wr_en, wr_addr, wr_data, rd_addr,
    input  base_address, load_weight,
    input  load_input, store_res, result_in,
    output rd_data, weights_out, weight_valid,
    output a_lane0, a_lane1, input_valid,
    output busy, done
  );
endinterface

// File: rtl/operand_buffer.sv
// 32x8 operand scratch memory + command sequencer feeding a 2x2 array.
// Ports: clk, rst_n (async low), bus (operand_buffer_if.slave).
module operand_buffer (
  input  logic clk,
  input  logic rst_n,
  operand_buffer_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH_W,
    S_FETCH_A,
    S_ISSUE_A,
    S_STORE
  } state_e;

  state_e           state_q, state_d;
  logic [1:0]       cnt_q, cnt_d;
  logic [4:0]       p_q, p_d;
  logic [3:0][7:0]  stage_q, stage_d;
  logic [31:0]      res_q, res_d;
  logic [31:0]      weights_q, weights_d;
  logic             wvalid_q, wvalid_d;
  logic             done_q, done_d;

  logic [7:0]       mem_q [32];

  logic [4:0]       op_addr;
  logic [7:0]       op_byte;
  logic             st_we;
  logic [7:0]       st_data;
  logic [7:0]       lane0;
  logic [7:0]       lane1;
  logic             in_valid;

  // p+k wraps naturally in 5 bits
  assign op_addr = p_q + {3'b000, cnt_q};
  assign op_byte = mem_q[op_addr];
  assign st_data = res_q[{cnt_q, 3'b000} +: 8];

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    p_d       = p_q;
    stage_d   = stage_q;
    res_d     = res_q;
    weights_d = weights_q;
    wvalid_d  = 1'b0;
    done_d    = 1'b0;
    st_we     = 1'b0;
    case (state_q)
      S_IDLE: begin
        cnt_d = 2'd0;
        if (bus.store_res) begin
          p_d     = bus.base_address;
          res_d   = bus.result_in;
          state_d = S_STORE;
        end else if (bus.load_weight) begin
          p_d     = bus.base_address;
          state_d = S_FETCH_W;
        end else if (bus.load_input) begin
          p_d     = bus.base_address;
          state_d = S_FETCH_A;
        end
      end
      S_FETCH_W: begin
        stage_d[cnt_q] = op_byte;
        cnt_d = cnt_q + 2'd1;
        if (cnt_q == 2'd3) begin
          // last byte bypasses staging
          weights_d = {op_byte, stage_q[2],
                       stage_q[1], stage_q[0]};
          wvalid_d  = 1'b1;
          done_d    = 1'b1;
          state_d   = S_IDLE;
        end
      end
      S_FETCH_A: begin
        stage_d[cnt_q] = op_byte;
        cnt_d = cnt_q + 2'd1;
        if (cnt_q == 2'd3) begin
          state_d = S_ISSUE_A;
        end
      end
      S_ISSUE_A: begin
        cnt_d = cnt_q + 2'd1;
        if (cnt_q == 2'd2) begin
          done_d  = 1'b1;
          state_d = S_IDLE;
        end
      end
      S_STORE: begin
        st_we = 1'b1;
        cnt_d = cnt_q + 2'd1;
        if (cnt_q == 2'd3) begin
          done_d  = 1'b1;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Diagonal skew: row 1 lags row 0 by one cycle
  always_comb begin
    lane0    = 8'd0;
    lane1    = 8'd0;
    in_valid = (state_q == S_ISSUE_A);
    if (in_valid) begin
      unique case (1'b1)
        cnt_q == 2'd0: lane0 = stage_q[0];
        cnt_q == 2'd1: begin
          lane0 = stage_q[1];
          lane1 = stage_q[2];
        end
        cnt_q == 2'd2: lane1 = stage_q[3];
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      cnt_q     <= 2'd0;
      p_q       <= 5'd0;
      stage_q   <= '0;
      res_q     <= 32'd0;
      weights_q <= 32'd0;
      wvalid_q  <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      p_q       <= p_d;
      stage_q   <= stage_d;
      res_q     <= res_d;
      weights_q <= weights_d;
      wvalid_q  <= wvalid_d;
      done_q    <= done_d;
    end
  end

  // Contents survive reset. Store write is last so it
  // wins an address collision with the host port.
  always_ff @(posedge clk) begin
    if (bus.wr_en) begin
      mem_q[bus.wr_addr] <= bus.wr_data;
    end
    if (st_we) begin
      mem_q[op_addr] <= st_data;
    end
  end

  assign bus.rd_data      = mem_q[bus.rd_addr];
  assign bus.weights_out  = weights_q;
  assign bus.weight_valid = wvalid_q;
  assign bus.a_lane0      = lane0;
  assign bus.a_lane1      = lane1;
  assign bus.input_valid  = in_valid;
  assign bus.busy         = (state_q != S_IDLE);
  assign bus.done         = done_q;

endmodule
